// File: rtl/rr_vc_arbiter_pkg.sv
// Shared constants and helpers for the round-robin VC arbiter: state encoding,
// index-width derivation and the explicit modulo-N increment used for the pointer.
package rr_vc_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Width of a VC index: ceil(log2(n)), never less than one bit.
  function automatic int vc_bits(input int n);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << b) < n) b = b + 1;
    end
    return (b == 0) ? 1 : b;
  endfunction

  // Wraps by comparison against n-1 so non-power-of-two counts rotate correctly.
  function automatic int inc_mod(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_vc_prio_enc.sv
// Rotated fixed-priority encoder: the first requesting VC at or after ptr
// (wrapping modulo NUM_VC) wins; masked VCs are excluded from the search.
import rr_vc_arbiter_pkg::*;

module rr_vc_prio_enc #(
  parameter int NUM_VC = 1,
  parameter int BW     = 1
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [BW-1:0]     ptr,
  input  logic [NUM_VC-1:0] mask,
  output logic [BW-1:0]     id,
  output logic              found
);

  logic [NUM_VC-1:0] masked;
  int unsigned       idx;
  logic [BW-1:0]     idx_b;

  assign masked = req & ~mask;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    found = 1'b0;
    id    = '0;
    idx   = 0;
    idx_b = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = 32'(ptr) + 32'(i);
      if (idx > 32'(NUM_VC - 1)) idx = idx - 32'(NUM_VC);
      idx_b = BW'(idx);
      if (!found && masked[idx_b]) begin
        found = 1'b1;
        id    = idx_b;
      end
    end
  end

endmodule

// File: rtl/rr_vc_arbiter.sv
// Round-robin VC arbiter with a registered, held one-hot grant and priority pointer.
// Optional packet locking (grant held until tail) when RR_VC_ARB_PKT_LOCK_EN is defined.
import rr_vc_arbiter_pkg::*;

module rr_vc_arbiter #(
  parameter int NUM_VC = 1,
  parameter int NUM_VN = 3,
  parameter int BW     = vc_bits(NUM_VC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_VC-1:0] req_in,
  input  logic [NUM_VC-1:0] tail_in,
  input  logic              accept_in,
  output logic [NUM_VC-1:0] grant_out,
  output logic [BW-1:0]     grant_id_out,
  output logic              grant_valid_out,
  output logic [BW-1:0]     ptr_out
);

  logic [1:0]        state, state_d;
  logic [BW-1:0]     ptr, ptr_d, ptr_inc, enc_ptr;
  logic [NUM_VC-1:0] grant_d, enc_mask, win_onehot;
  logic [BW-1:0]     id_d, win_id;
  logic              win_found, granted, advance, hold_lock;
  logic              unused_sig;

  assign granted = (state != ST_IDLE);
  assign ptr_inc = BW'(inc_mod(32'(grant_id_out), NUM_VC));

`ifdef RR_VC_ARB_PKT_LOCK_EN
  assign hold_lock  = !tail_in[grant_id_out];
  assign unused_sig = (NUM_VN != 0);
`else
  assign hold_lock  = 1'b0;
  assign unused_sig = (NUM_VN != 0) & (^tail_in);
`endif

  // Accepting the live grant advances the pointer and re-arbitrates in the same cycle.
  assign advance  = granted && accept_in && !hold_lock;
  assign enc_ptr  = advance ? ptr_inc : ptr;
  assign enc_mask = advance ? grant_out : '0;

  rr_vc_prio_enc #(.NUM_VC(NUM_VC), .BW(BW)) u_enc (
    .req   (req_in),
    .ptr   (enc_ptr),
    .mask  (enc_mask),
    .id    (win_id),
    .found (win_found)
  );

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NUM_VC; i++) win_onehot[i] = (win_id == BW'(i));
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    grant_d = grant_out;
    id_d    = grant_id_out;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          grant_d = win_onehot;
          id_d    = win_id;
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED, ST_LOCKED: begin
        if (accept_in && hold_lock) begin
          state_d = ST_LOCKED;
        end else if (advance) begin
          ptr_d = ptr_inc;
          if (win_found) begin
            grant_d = win_onehot;
            id_d    = win_id;
            state_d = ST_GRANTED;
          end else begin
            grant_d = '0;
            id_d    = '0;
            state_d = ST_IDLE;
          end
        end else if (!req_in[grant_id_out]) begin
          grant_d = '0;
          id_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        id_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      grant_out    <= '0;
      grant_id_out <= '0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      grant_out    <= grant_d;
      grant_id_out <= id_d;
    end
  end

  assign grant_valid_out = |grant_out;
  assign ptr_out         = ptr;

endmodule

// File: tb/tb_rr_vc_arbiter.sv
// Scoreboard bench for rr_vc_arbiter (NUM_VC=4): stimulus pushes the expected
// post-edge outputs; a negedge monitor pops and compares them.
module tb_rr_vc_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_in = '0;
  logic [3:0] tail_in = '0;
  logic       accept_in = 1'b0;
  logic [3:0] grant_out;
  logic [1:0] grant_id_out;
  logic       grant_valid_out;
  logic [1:0] ptr_out;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] grant;
    logic [1:0] id;
    logic       valid;
    logic [1:0] ptr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  rr_vc_arbiter #(.NUM_VC(4), .NUM_VN(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_in          (req_in),
    .tail_in         (tail_in),
    .accept_in       (accept_in),
    .grant_out       (grant_out),
    .grant_id_out    (grant_id_out),
    .grant_valid_out (grant_valid_out),
    .ptr_out         (ptr_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got grant/id/valid/ptr=%b required %b (cycle %0d)", name, act, req, cyc);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string name, input logic rst, input logic [3:0] req,
                      input logic [3:0] tail, input logic acc,
                      input logic ev, input logic [1:0] eid, input logic [1:0] eptr);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; req_in = req; tail_in = tail; accept_in = acc;
    e.cyc   = cyc + 1;
    e.name  = name;
    e.valid = ev;
    e.id    = eid;
    e.ptr   = eptr;
    e.grant = ev ? (4'b0001 << eid) : 4'b0000;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, {grant_out, grant_id_out, grant_valid_out, ptr_out},
            {e.grant, e.id, e.valid, e.ptr});
    end
  end

  initial begin
    // 1: reset with all requests, then first grant is VC0
    step("rst0",      1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 2'd0, 2'd0);
    step("rst1",      1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 2'd0, 2'd0);
    step("first",     1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0, 2'd0);
    // 2: full load, accept every cycle
    step("rr1",       1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 2'd1);
    step("rr2",       1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 2'd2);
    step("rr3",       1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 2'd3);
    step("rr0",       1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 2'd0);
    step("rr_drain",  1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd1);
    // 3: sparse requests and pointer wrap
    step("rst3",      1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0, 2'd0);
    step("sp_g1",     1'b1, 4'b1010, 4'b1111, 1'b0, 1'b1, 2'd1, 2'd0);
    step("sp_g3",     1'b1, 4'b1010, 4'b1111, 1'b1, 1'b1, 2'd3, 2'd2);
    step("sp_wrap",   1'b1, 4'b1010, 4'b1111, 1'b1, 1'b1, 2'd1, 2'd0);
    step("sp_drain",  1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd2);
    // 4: hold without accept, cancel, ignored accept, accept+drop
    step("hold_g2",   1'b1, 4'b0100, 4'b1111, 1'b0, 1'b1, 2'd2, 2'd2);
    step("hold_a",    1'b1, 4'b0100, 4'b1111, 1'b0, 1'b1, 2'd2, 2'd2);
    step("hold_b",    1'b1, 4'b1101, 4'b1111, 1'b0, 1'b1, 2'd2, 2'd2);
    step("hold_c",    1'b1, 4'b0111, 4'b1111, 1'b0, 1'b1, 2'd2, 2'd2);
    step("cancel",    1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0, 2'd2);
    step("acc_idle",  1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd2);
    step("regrant",   1'b1, 4'b0100, 4'b1111, 1'b0, 1'b1, 2'd2, 2'd2);
    step("acc_drop",  1'b1, 4'b0001, 4'b1111, 1'b1, 1'b1, 2'd0, 2'd3);
    step("drain4",    1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 2'd1);
    // 5: packet lock vs flit-level round robin
    step("rst5",      1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0);
    step("pk_g0",     1'b1, 4'b0011, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0);
`ifdef RR_VC_ARB_PKT_LOCK_EN
    step("pk_f1",     1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0);
    step("pk_f2",     1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd0);
`else
    step("pk_f1",     1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1);
    step("pk_f2",     1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd2);
`endif
    step("pk_tail",   1'b1, 4'b0011, 4'b0001, 1'b1, 1'b1, 2'd1, 2'd1);
    // 6: reset while granted on VC2
    step("g2",        1'b1, 4'b0100, 4'b1111, 1'b1, 1'b1, 2'd2, 2'd2);
    step("rst6",      1'b0, 4'b0100, 4'b1111, 1'b0, 1'b0, 2'd0, 2'd0);
    step("idle6",     1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0, 2'd0);
    step("post_rst",  1'b1, 4'b1000, 4'b1111, 1'b0, 1'b1, 2'd3, 2'd0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expectations required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of run required finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
